serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer: sits directly upstream of the 1-bit full-adder

---
 rtl/serial_add_ctrl_if.sv | 29 ++
 rtl/serial_add_ctrl.sv | 99 +++++++++
 tb/tb_serial_add_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Host handshake plus the wires to the external 1-bit full-adder cell.
// The slave side is the sequencer and the master side is the host/adder environment.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_ci;
  logic             fa_s;
  logic             fa_co;

  modport master (
    output start, a, b, cin, fa_s, fa_co,
    input  busy, done, sum, cout, fa_a, fa_b, fa_ci
  );

  modport slave (
    input  start, a, b, cin, fa_s, fa_co,
    output busy, done, sum, cout, fa_a, fa_b, fa_ci
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external full adder one bit pair per
// clock (LSB first), keeps the carry in a flop and assembles the sum bits.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aReg_q;
  logic [WIDTH-1:0] bReg_q;
  logic [WIDTH-1:0] sumShift_q;
  logic [WIDTH-1:0] sumShift_d;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             inShift;

  assign inShift    = (state_q == SHIFT);
  assign bus.fa_a   = inShift & aReg_q[0];
  assign bus.fa_b   = inShift & bReg_q[0];
  assign bus.fa_ci  = inShift & carry_q;

  // Returned sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign sumShift_d = WIDTH'({bus.fa_s, sumShift_q} >> 1);

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      aReg_q     <= '0;
      bReg_q     <= '0;
      sumShift_q <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            aReg_q  <= bus.a;
            bReg_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sumShift_q <= sumShift_d;
          carry_q    <= bus.fa_co;
          aReg_q     <= aReg_q >> 1;
          bReg_q     <= bReg_q >> 1;
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            sum_q   <= sumShift_d;
            cout_q  <= bus.fa_co;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder on the fa_* wires
// and a reference model of {cout,sum} = a + b + cin.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  bit   checkerOn;
  logic [W:0] prevRes;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.fa_s  = bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
  assign bus.fa_co = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_ci) | (bus.fa_b & bus.fa_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder wires must be quiet outside SHIFT, and the result may only move when done rises.
  always @(negedge clk) begin
    if (reset_n && checkerOn) begin
      if (!bus.busy || bus.done) begin
        checks++;
        if ({bus.fa_a, bus.fa_b, bus.fa_ci} !== 3'b000) begin
          errors++;
          $display("[TB] FAIL fa_quiet: got %b expected 000", {bus.fa_a, bus.fa_b, bus.fa_ci});
        end
      end
      if (!bus.done) begin
        checks++;
        if ({bus.cout, bus.sum} !== prevRes) begin
          errors++;
          $display("[TB] FAIL result_hold: got %h expected %h", {bus.cout, bus.sum}, prevRes);
        end
      end
    end
    prevRes = {bus.cout, bus.sum};
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic s, input logic [W-1:0] opA,
                               input logic [W-1:0] opB, input logic opC);
    bus.start = s;
    bus.a     = opA;
    bus.b     = opB;
    bus.cin   = opC;
  endtask

  // Runs one add from IDLE; scrambles a/b/cin while busy and pulses start per pulseMask.
  task automatic runOp(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opC,
                       input logic [15:0] pulseMask,
                       output logic [W-1:0] gotSum, output logic gotCout,
                       output int edges, output bit busyGap, output bit timedOut);
    @(negedge clk);
    applyStimulus(1'b1, opA, opB, opC);
    @(posedge clk);
    edges    = 0;
    busyGap  = 0;
    timedOut = 0;
    forever begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busyGap = 1;
      if (edges > 40) begin
        timedOut = 1;
        break;
      end
      applyStimulus(edges < 16 ? pulseMask[edges] : 1'b0,
                    W'($urandom), W'($urandom), 1'($urandom));
    end
    gotSum  = bus.sum;
    gotCout = bus.cout;
    applyStimulus(edges < 16 ? pulseMask[edges] : 1'b0,
                  W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_reset;
    applyStimulus(1'b0, '0, '0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.cout});
    end
    checks++;
    if (bus.sum !== '0) begin
      errors++;
      $display("[TB] FAIL reset_sum: got %h expected 00", bus.sum);
    end
    checks++;
    if ({bus.fa_a, bus.fa_b, bus.fa_ci} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_fa: got %b expected 000", {bus.fa_a, bus.fa_b, bus.fa_ci});
    end
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %h expected 000", {bus.busy, bus.done, bus.cout, bus.sum});
    end
    prevRes   = {bus.cout, bus.sum};
    checkerOn = 1;
  endtask

  task automatic test_basic;
    logic [W-1:0] s;
    logic c;
    int e;
    bit gap, to;
    runOp(8'h3C, 8'h5A, 1'b0, 16'h0000, s, c, e, gap, to);
    checks++;
    if ({c, s} !== 9'h096) begin
      errors++;
      $display("[TB] FAIL basic_sum: got %h expected 096", {c, s});
    end
    checks++;
    if (e !== W || to) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", e, W);
    end
    checks++;
    if (gap) begin
      errors++;
      $display("[TB] FAIL basic_busy: got busy low before done expected high");
    end
  endtask

  task automatic test_carry;
    logic [W-1:0] s;
    logic c;
    int e;
    bit gap, to;
    runOp(8'hFF, 8'h01, 1'b0, 16'h0000, s, c, e, gap, to);
    checks++;
    if ({c, s} !== 9'h100 || to) begin
      errors++;
      $display("[TB] FAIL carry_ff_01: got %h expected 100", {c, s});
    end
    runOp(8'hFF, 8'hFF, 1'b1, 16'h0000, s, c, e, gap, to);
    checks++;
    if ({c, s} !== 9'h1FF || to) begin
      errors++;
      $display("[TB] FAIL carry_ripple: got %h expected 1ff", {c, s});
    end
  endtask

  task automatic test_start_ignored;
    logic [W-1:0] s;
    logic c;
    int e;
    bit gap, to;
    runOp(8'h3C, 8'h5A, 1'b1, 16'h0108, s, c, e, gap, to);
    checks++;
    if ({c, s} !== 9'h097) begin
      errors++;
      $display("[TB] FAIL ignore_sum: got %h expected 097", {c, s});
    end
    checks++;
    if (e !== W || to || gap) begin
      errors++;
      $display("[TB] FAIL ignore_timing: got latency %0d gap %0d expected %0d 0", e, gap, W);
    end
    repeat (4) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL ignore_no_restart: got busy,done %b expected 00", {bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_reset_abort;
    bit sawDone;
    logic [W-1:0] s;
    logic c;
    int e;
    bit gap, to;
    @(negedge clk);
    applyStimulus(1'b1, 8'hA5, 8'h3C, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum, bus.fa_a, bus.fa_b, bus.fa_ci} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_clear: got %h expected 000",
               {bus.busy, bus.done, bus.cout, bus.sum, bus.fa_a, bus.fa_b, bus.fa_ci});
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    sawDone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) sawDone = 1;
    end
    checks++;
    if (sawDone) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got activity after reset expected none");
    end
    runOp(8'h01, 8'h01, 1'b0, 16'h0000, s, c, e, gap, to);
    checks++;
    if ({c, s} !== 9'h002 || to) begin
      errors++;
      $display("[TB] FAIL abort_next_op: got %h expected 002", {c, s});
    end
  endtask

  // start held high: accepts land every W+2 edges, each on its own a/b/cin.
  task automatic test_back_to_back;
    logic [W:0] expQ[$];
    logic [W:0] expV;
    logic [W-1:0] ra, rb;
    logic rc;
    @(negedge clk);
    for (int n = 0; n < 5 * (W + 2); n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      applyStimulus(1'b1, ra, rb, rc);
      if (n % (W + 2) == 0) expQ.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (n % (W + 2) == W) begin
        expV = expQ.pop_front();
        if (bus.done !== 1'b1 || {bus.cout, bus.sum} !== expV) begin
          errors++;
          $display("[TB] FAIL b2b_result: edge %0d got done %b res %h expected done 1 res %h",
                   n, bus.done, {bus.cout, bus.sum}, expV);
        end
      end else if (bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_done: edge %0d got done %b expected 0", n, bus.done);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb, s;
    logic rc, c;
    logic [W:0] expV;
    int e;
    bit gap, to;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        ra = '0;
        rb = '0;
        rc = 1'b1;
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
      end
      expV = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      runOp(ra, rb, rc, 16'h0000, s, c, e, gap, to);
      checks++;
      if ({c, s} !== expV) begin
        errors++;
        $display("[TB] FAIL rand_result: op %0d %h+%h+%b got %h expected %h", i, ra, rb, rc, {c, s}, expV);
      end
      checks++;
      if (e !== W || to || gap) begin
        errors++;
        $display("[TB] FAIL rand_timing: op %0d got latency %0d gap %0d expected %0d 0", i, e, gap, W);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    checkerOn = 0;
    prevRes   = '0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
